// File: rtl/alu_rs_if.sv
// Issue, CDB and execute bundle between the dispatch allocator,
// the ALU reservation station and the ALU execute unit.
interface alu_rs_if #(
  parameter int TAG_W  = 4,
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
);
  logic              en_in;
  logic [OP_W-1:0]   op_in;
  logic [WORD_W-1:0] pc_in;
  logic [TAG_W-1:0]  tagx_in;
  logic [WORD_W-1:0] datax_in;
  logic [TAG_W-1:0]  tagy_in;
  logic [WORD_W-1:0] datay_in;
  logic [TAG_W-1:0]  tagw_in;
  logic [4:0]        addrw_in;
  logic              cdb_en;
  logic [TAG_W-1:0]  cdb_tag;
  logic [WORD_W-1:0] cdb_data;
  logic              busy_out;
  logic [TAG_W-1:0]  tagx_out;
  logic [TAG_W-1:0]  tagy_out;
  logic [TAG_W-1:0]  tagw_out;
  logic              ex_stall;
  logic              ex_en;
  logic [OP_W-1:0]   ex_op;
  logic [WORD_W-1:0] ex_a;
  logic [WORD_W-1:0] ex_b;
  logic [TAG_W-1:0]  ex_tagw;
  logic [4:0]        ex_addrw;
  logic [WORD_W-1:0] ex_pc;

  modport master (
    output en_in, op_in, pc_in, tagx_in, datax_in, tagy_in, datay_in,
           tagw_in, addrw_in, cdb_en, cdb_tag, cdb_data, ex_stall,
    input  busy_out, tagx_out, tagy_out, tagw_out,
           ex_en, ex_op, ex_a, ex_b, ex_tagw, ex_addrw, ex_pc
  );

  modport slave (
    input  en_in, op_in, pc_in, tagx_in, datax_in, tagy_in, datay_in,
           tagw_in, addrw_in, cdb_en, cdb_tag, cdb_data, ex_stall,
    output busy_out, tagx_out, tagy_out, tagw_out,
           ex_en, ex_op, ex_a, ex_b, ex_tagw, ex_addrw, ex_pc
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed ops until operands arrive via CDB, fires one per cycle.
// Optional ALU_RS_CDB_FWD_EN: select/fire may consume the live CDB value in the same cycle.
module alu_rs #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    flush,
  alu_rs_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [WORD_W-1:0] pc_q    [DEPTH];
  logic [TAG_W-1:0]  tagx_q  [DEPTH];
  logic [WORD_W-1:0] datax_q [DEPTH];
  logic [TAG_W-1:0]  tagy_q  [DEPTH];
  logic [WORD_W-1:0] datay_q [DEPTH];
  logic [TAG_W-1:0]  tagw_q  [DEPTH];
  logic [4:0]        addrw_q [DEPTH];

  logic              ex_en_q;
  logic [OP_W-1:0]   ex_op_q;
  logic [WORD_W-1:0] ex_a_q;
  logic [WORD_W-1:0] ex_b_q;
  logic [TAG_W-1:0]  ex_tagw_q;
  logic [4:0]        ex_addrw_q;
  logic [WORD_W-1:0] ex_pc_q;

  logic              cdb_live;
  logic              busy;
  logic [DEPTH-1:0]  ready_vec;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  head_idx;
  logic              sel_vld;
  logic              head_vld;
  logic              fire;
  logic [WORD_W-1:0] fire_a;
  logic [WORD_W-1:0] fire_b;

  assign cdb_live = bus.cdb_en && (bus.cdb_tag != '0);
  assign busy     = &valid;
  assign fire     = sel_vld && !bus.ex_stall;

  always_comb begin
    ready_vec = '0;
    sel_idx   = '0;
    sel_vld   = 1'b0;
    free_idx  = '0;
    head_idx  = '0;
    head_vld  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef ALU_RS_CDB_FWD_EN
      ready_vec[i] = valid[i]
                  && ((tagx_q[i] == '0) || (cdb_live && (tagx_q[i] == bus.cdb_tag)))
                  && ((tagy_q[i] == '0) || (cdb_live && (tagy_q[i] == bus.cdb_tag)));
`else
      ready_vec[i] = valid[i] && (tagx_q[i] == '0) && (tagy_q[i] == '0);
`endif
    end
    // Scan downwards so the lowest matching index is the one left standing.
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (ready_vec[i-1]) begin
        sel_idx = IDX_W'(i - 1);
        sel_vld = 1'b1;
      end
      if (!valid[i-1]) free_idx = IDX_W'(i - 1);
      if (valid[i-1]) begin
        head_idx = IDX_W'(i - 1);
        head_vld = 1'b1;
      end
    end
    fire_a = datax_q[sel_idx];
    fire_b = datay_q[sel_idx];
`ifdef ALU_RS_CDB_FWD_EN
    if (tagx_q[sel_idx] != '0) fire_a = bus.cdb_data;
    if (tagy_q[sel_idx] != '0) fire_b = bus.cdb_data;
`endif
  end

  assign bus.busy_out = busy;
  assign bus.tagx_out = head_vld ? tagx_q[head_idx] : '0;
  assign bus.tagy_out = head_vld ? tagy_q[head_idx] : '0;
  assign bus.tagw_out = (!head_vld || (fire && (sel_idx == head_idx))) ? '0 : tagw_q[head_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      ex_en_q    <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_tagw_q  <= '0;
      ex_addrw_q <= '0;
      ex_pc_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        pc_q[i]    <= '0;
        tagx_q[i]  <= '0;
        datax_q[i] <= '0;
        tagy_q[i]  <= '0;
        datay_q[i] <= '0;
        tagw_q[i]  <= '0;
        addrw_q[i] <= '0;
      end
    end else if (!rdy) begin
      ex_en_q <= 1'b0;
    end else if (flush) begin
      valid   <= '0;
      ex_en_q <= 1'b0;
    end else begin
      ex_en_q <= fire;
      if (fire) begin
        ex_op_q         <= op_q[sel_idx];
        ex_a_q          <= fire_a;
        ex_b_q          <= fire_b;
        ex_tagw_q       <= tagw_q[sel_idx];
        ex_addrw_q      <= addrw_q[sel_idx];
        ex_pc_q         <= pc_q[sel_idx];
        valid[sel_idx]  <= 1'b0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid[i] && cdb_live && (tagx_q[i] == bus.cdb_tag)) begin
          tagx_q[i]  <= '0;
          datax_q[i] <= bus.cdb_data;
        end
        if (valid[i] && cdb_live && (tagy_q[i] == bus.cdb_tag)) begin
          tagy_q[i]  <= '0;
          datay_q[i] <= bus.cdb_data;
        end
      end
      // free_idx comes from registered valid, so a slot vacated by this edge's fire is never picked.
      if (bus.en_in && !busy) begin
        valid[free_idx]   <= 1'b1;
        op_q[free_idx]    <= bus.op_in;
        pc_q[free_idx]    <= bus.pc_in;
        tagw_q[free_idx]  <= bus.tagw_in;
        addrw_q[free_idx] <= bus.addrw_in;
        if (cdb_live && (bus.tagx_in == bus.cdb_tag)) begin
          tagx_q[free_idx]  <= '0;
          datax_q[free_idx] <= bus.cdb_data;
        end else begin
          tagx_q[free_idx]  <= bus.tagx_in;
          datax_q[free_idx] <= bus.datax_in;
        end
        if (cdb_live && (bus.tagy_in == bus.cdb_tag)) begin
          tagy_q[free_idx]  <= '0;
          datay_q[free_idx] <= bus.cdb_data;
        end else begin
          tagy_q[free_idx]  <= bus.tagy_in;
          datay_q[free_idx] <= bus.datay_in;
        end
      end
    end
  end

  assign bus.ex_en    = ex_en_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_tagw  = ex_tagw_q;
  assign bus.ex_addrw = ex_addrw_q;
  assign bus.ex_pc    = ex_pc_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs (default build, ALU_RS_CDB_FWD_EN undefined).
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  alu_rs_if #(.TAG_W(4), .WORD_W(32), .OP_W(4)) bus ();

  alu_rs #(.DEPTH(4), .TAG_W(4), .WORD_W(32), .OP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en_in    = 1'b0;
    bus.op_in    = '0;
    bus.pc_in    = '0;
    bus.tagx_in  = '0;
    bus.datax_in = '0;
    bus.tagy_in  = '0;
    bus.datay_in = '0;
    bus.tagw_in  = '0;
    bus.addrw_in = '0;
    bus.cdb_en   = 1'b0;
    bus.cdb_tag  = '0;
    bus.cdb_data = '0;
    bus.ex_stall = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] tx, input logic [31:0] dx,
                       input logic [3:0] ty, input logic [31:0] dy, input logic [3:0] tw);
    bus.en_in    = 1'b1;
    bus.op_in    = op;
    bus.tagx_in  = tx;
    bus.datax_in = dx;
    bus.tagy_in  = ty;
    bus.datay_in = dy;
    bus.tagw_in  = tw;
    bus.addrw_in = 5'(tw) + 5'd16;
    bus.pc_in    = 32'h1000 + 32'(tw) * 4;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_en   = 1'b1;
    bus.cdb_tag  = tag;
    bus.cdb_data = data;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    idle();
    tick();
    tick();
    check("rst_ex_en", bus.ex_en, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_tagw_out", bus.tagw_out, 0);
    check("rst_ex_a", bus.ex_a, 0);
    rst = 1'b0;

    // Three waiting entries, then asynchronous reset in mid-cycle.
    for (int i = 0; i < 3; i++) begin
      issue(4'd1, 4'd5, 32'd0, 4'd0, 32'd0, 4'(i + 1));
      tick();
    end
    idle();
    check("pre_rst_tagx", bus.tagx_out, 5);
    check("pre_rst_tagw", bus.tagw_out, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy_out, 0);
    check("midrst_ex_en", bus.ex_en, 0);
    check("midrst_tagx", bus.tagx_out, 0);
    check("midrst_tagw", bus.tagw_out, 0);
    tick();
    rst = 1'b0;
    issue(4'd2, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
    tick();
    idle();
    check("iss_ex_en_early", bus.ex_en, 0);
    check("iss_tagw_firing", bus.tagw_out, 0);
    tick();
    check("iss_ex_en", bus.ex_en, 1);
    check("iss_ex_a", bus.ex_a, 5);
    check("iss_ex_b", bus.ex_b, 7);
    check("iss_ex_op", bus.ex_op, 2);
    check("iss_ex_pc", bus.ex_pc, 32'h100c);
    check("iss_ex_addrw", bus.ex_addrw, 19);
    tick();
    check("iss_pulse", bus.ex_en, 0);
    check("iss_empty_tagx", bus.tagx_out, 0);

    // Wakeup from CDB.
    issue(4'd1, 4'd3, 32'hbad, 4'd0, 32'd1, 4'd9);
    tick();
    idle();
    check("wk_tagx_before", bus.tagx_out, 3);
    check("wk_tagw_before", bus.tagw_out, 9);
    tick();
    check("wk_wait", bus.ex_en, 0);
    cdb(4'd3, 32'h10);
    tick();
    idle();
    check("wk_tagx_after", bus.tagx_out, 0);
    check("wk_no_fire_yet", bus.ex_en, 0);
    tick();
    check("wk_ex_en", bus.ex_en, 1);
    check("wk_ex_a", bus.ex_a, 32'h10);
    check("wk_ex_b", bus.ex_b, 1);
    check("wk_ex_tagw", bus.ex_tagw, 9);
    tick();

    // Issue-time bypass on operand y.
    issue(4'd3, 4'd0, 32'd4, 4'd6, 32'hdead, 4'd10);
    cdb(4'd6, 32'd9);
    tick();
    idle();
    check("byp_tagy", bus.tagy_out, 0);
    tick();
    check("byp_ex_en", bus.ex_en, 1);
    check("byp_ex_a", bus.ex_a, 4);
    check("byp_ex_b", bus.ex_b, 9);
    tick();

    // Full: four waiting entries, fifth issue ignored, then one broadcast drains in order.
    for (int i = 0; i < 4; i++) begin
      issue(4'd4, 4'd2, 32'd0, 4'd0, 32'(i), 4'(i + 1));
      tick();
    end
    check("full_busy", bus.busy_out, 1);
    issue(4'd5, 4'd0, 32'd1, 4'd0, 32'd1, 4'd15);
    tick();
    idle();
    check("full_still_busy", bus.busy_out, 1);
    check("full_no_fire", bus.ex_en, 0);
    cdb(4'd2, 32'h22);
    tick();
    idle();
    check("full_busy_capt", bus.busy_out, 1);
    check("full_capt_no_fire", bus.ex_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_ex_en", bus.ex_en, 1);
      check("full_ex_b", bus.ex_b, 32'(i));
      check("full_ex_tagw", bus.ex_tagw, 32'(i + 1));
      check("full_ex_a", bus.ex_a, 32'h22);
      check("full_busy_drain", bus.busy_out, 0);
    end
    tick();
    check("full_fifth_dropped", bus.ex_en, 0);

    // Stall holds a ready entry.
    issue(4'd6, 4'd0, 32'ha, 4'd0, 32'hb, 4'd7);
    bus.ex_stall = 1'b1;
    tick();
    bus.en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_ex_en", bus.ex_en, 0);
      check("stl_tagw_out", bus.tagw_out, 7);
      check("stl_ex_hold", bus.ex_tagw, 4);
    end
    bus.ex_stall = 1'b0;
    #1;
    check("stl_release_tagw", bus.tagw_out, 0);
    tick();
    check("stl_fire", bus.ex_en, 1);
    check("stl_fire_tagw", bus.ex_tagw, 7);
    check("stl_fire_a", bus.ex_a, 32'ha);
    tick();
    check("stl_single_pulse", bus.ex_en, 0);

    // Flush with a simultaneous issue, then late broadcasts must not revive anything.
    issue(4'd1, 4'd10, 32'd0, 4'd0, 32'd0, 4'd1);
    tick();
    issue(4'd1, 4'd11, 32'd0, 4'd0, 32'd0, 4'd2);
    tick();
    check("fl_pre_tagx", bus.tagx_out, 10);
    issue(4'd1, 4'd0, 32'd1, 4'd0, 32'd2, 4'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_tagx", bus.tagx_out, 0);
    check("fl_ex_en", bus.ex_en, 0);
    cdb(4'd10, 32'h1);
    tick();
    cdb(4'd11, 32'h2);
    tick();
    idle();
    check("fl_no_fire_a", bus.ex_en, 0);
    tick();
    check("fl_no_fire_b", bus.ex_en, 0);

    // rdy low across a broadcast: tag is not captured.
    issue(4'd8, 4'd12, 32'd0, 4'd0, 32'd3, 4'd5);
    tick();
    idle();
    rdy = 1'b0;
    cdb(4'd12, 32'h33);
    tick();
    check("rdy_ex_en", bus.ex_en, 0);
    rdy = 1'b1;
    idle();
    tick();
    check("rdy_tagx_kept", bus.tagx_out, 12);
    check("rdy_no_fire", bus.ex_en, 0);
    cdb(4'd12, 32'h44);
    tick();
    idle();
    tick();
    check("rdy_late_fire", bus.ex_en, 1);
    check("rdy_late_a", bus.ex_a, 32'h44);
    check("rdy_late_op", bus.ex_op, 8);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
